// File: rtl/ste_bin2bcd_seq.sv
// Purpose : sequential double-dabble binary-to-BCD converter, one shift step per clock.
// Latency : din_valid_i at edge N -> bcd_o/overflow_o updated and bcd_valid_o=1 after edge N+DATA_W.
// Backpr. : none; updates arriving mid-conversion go to a one-entry pending slot (latest wins).
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   din_i         unsigned value, sampled only when din_valid_i=1
//   din_valid_i   1-cycle input strobe
//   clr_i         synchronous clear: abort conversion, drop pending, zero outputs
//   bcd_o         packed BCD, digit k at [4k+3:4k], k=0 units; held between pulses
//   bcd_valid_o   1-cycle pulse when bcd_o/overflow_o update
//   busy_o        high while a conversion is shifting
//   overflow_o    last published value exceeded 10^DIGITS-1 (bcd_o is value mod 10^DIGITS)
module ste_bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din_i,
    input  logic                  din_valid_i,
    input  logic                  clr_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_valid_o,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [DATA_W-1:0]     shift_q,     shift_d;
    logic [4*DIGITS-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  ovf_q,       ovf_d;
    logic                  pend_vld_q,  pend_vld_d;
    logic [DATA_W-1:0]     pend_dat_q,  pend_dat_d;
    logic [4*DIGITS-1:0]   bcd_q,       bcd_d;
    logic                  bcd_vld_q,   bcd_vld_d;
    logic                  overflow_q,  overflow_d;

    // One double-dabble step on the current accumulator/shift register.
    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_step;
    logic [DATA_W-1:0]     shift_step;
    logic                  carry_out;

    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        // carry_out is the bit leaving the top digit; nonzero means value >= 10^DIGITS.
        {carry_out, acc_step, shift_step} = {acc_adj, shift_q, 1'b0};
    end

    logic              load_en;
    logic [DATA_W-1:0] load_val;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        bcd_d      = bcd_q;
        bcd_vld_d  = 1'b0;
        overflow_d = overflow_q;
        load_en    = 1'b0;
        load_val   = din_i;

        case (state_q)
            ST_IDLE: begin
                if (din_valid_i) begin
                    load_en = 1'b1;
                end
            end
            ST_SHIFT: begin
                shift_d = shift_step;
                acc_d   = acc_step;
                ovf_d   = ovf_q | carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d      = acc_step;
                    overflow_d = ovf_q | carry_out;
                    bcd_vld_d  = 1'b1;
                    if (din_valid_i) begin
                        // A fresh sample is newer than anything pending, so the
                        // pending value is dropped rather than published out of order.
                        load_en    = 1'b1;
                        pend_vld_d = 1'b0;
                    end else if (pend_vld_q) begin
                        load_en    = 1'b1;
                        load_val   = pend_dat_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (din_valid_i) begin
                    pend_vld_d = 1'b1;
                    pend_dat_d = din_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            state_d = ST_SHIFT;
            shift_d = load_val;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        if (clr_i) begin
            state_d    = ST_IDLE;
            pend_vld_d = 1'b0;
            bcd_d      = '0;
            overflow_d = 1'b0;
            bcd_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            bcd_q      <= '0;
            bcd_vld_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            bcd_q      <= bcd_d;
            bcd_vld_q  <= bcd_vld_d;
            overflow_q <= overflow_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = bcd_vld_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_ste_bin2bcd_seq.sv
// Purpose : directed bench for ste_bin2bcd_seq (5-digit and 4-digit instances share stimulus).
// Latency : results expected exactly 16 cycles after the accepting edge.
// Backpr. : none; exercises pending-slot overwrite, back-to-back load, clear and reset.
module tb_ste_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_i;
    logic        din_valid_i;
    logic        clr_i;
    logic [19:0] bcd_o;
    logic        bcd_valid_o, busy_o, overflow_o;
    logic [15:0] bcd4_o;
    logic        bcd4_valid_o, busy4_o, overflow4_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ste_bin2bcd_seq #(.DATA_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_valid_i(din_valid_i), .clr_i(clr_i),
        .bcd_o(bcd_o), .bcd_valid_o(bcd_valid_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    ste_bin2bcd_seq #(.DATA_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_valid_i(din_valid_i), .clr_i(clr_i),
        .bcd_o(bcd4_o), .bcd_valid_o(bcd4_valid_o), .busy_o(busy4_o), .overflow_o(overflow4_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v for exactly one edge; return #1 after that edge with garbage on din_i.
    task automatic send(input logic [15:0] v);
        din_i       = v;
        din_valid_i = 1'b1;
        step();
        din_valid_i = 1'b0;
        din_i       = 16'($urandom);
    endtask

    // Step until the next bcd_valid_o pulse (bounded); cyc counts edges, bc counts busy samples.
    task automatic wait_next(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        do begin
            if (busy_o) bc++;
            din_i = 16'($urandom);
            step();
            cyc++;
        end while (!bcd_valid_o && cyc < 100);
    endtask

    int cyc, bc, pulses;

    initial begin
        rst_n = 1'b0; din_i = 16'hABCD; din_valid_i = 1'b0; clr_i = 1'b0;
        step(); step();
        chk("rst_bcd",   32'(bcd_o), 32'h0);
        chk("rst_vld",   32'(bcd_valid_o), 32'h0);
        chk("rst_busy",  32'(busy_o), 32'h0);
        chk("rst_ovf",   32'(overflow_o), 32'h0);
        rst_n = 1'b1;
        step();

        // zero input
        send(16'd0);
        chk("t1_busy", 32'(busy_o), 32'h1);
        wait_next(cyc, bc);
        chk("t1_lat",  32'(cyc), 32'd16);
        chk("t1_bcd",  32'(bcd_o), 32'h00000);
        chk("t1_ovf",  32'(overflow_o), 32'h0);
        chk("t1_idle", 32'(busy_o), 32'h0);
        step();
        chk("t1_pulse", 32'(bcd_valid_o), 32'h0);

        // 12345
        send(16'h3039);
        wait_next(cyc, bc);
        chk("t2_lat",   32'(cyc), 32'd16);
        chk("t2_busy",  32'(bc), 32'd16);
        chk("t2_bcd",   32'(bcd_o), 32'h12345);
        chk("t2_ovf",   32'(overflow_o), 32'h0);
        chk("t2_bcd4",  32'(bcd4_o), 32'h2345);
        chk("t2_ovf4",  32'(overflow4_o), 32'h1);
        step();
        chk("t2_hold",  32'(bcd_o), 32'h12345);

        // full-scale and 4-digit overflow boundary
        send(16'hFFFF);
        wait_next(cyc, bc);
        chk("t3_bcd",   32'(bcd_o), 32'h65535);
        chk("t3_ovf",   32'(overflow_o), 32'h0);
        chk("t3_bcd4",  32'(bcd4_o), 32'h5535);
        send(16'd9999);
        wait_next(cyc, bc);
        chk("t3_9999_4", 32'(bcd4_o), 32'h9999);
        chk("t3_9999_o", 32'(overflow4_o), 32'h0);
        send(16'd10000);
        wait_next(cyc, bc);
        chk("t3_10k",    32'(bcd_o), 32'h10000);
        chk("t3_10k_4",  32'(bcd4_o), 32'h0000);
        chk("t3_10k_o4", 32'(overflow4_o), 32'h1);

        // pending slot: latest wins
        send(16'd100);
        step(); step(); step();
        send(16'd200);
        step(); step();
        send(16'd300);
        wait_next(cyc, bc);
        chk("t4_first",  32'(bcd_o), 32'h00100);
        chk("t4_ovf4",   32'(overflow4_o), 32'h0);
        wait_next(cyc, bc);
        chk("t4_gap",    32'(cyc), 32'd16);
        chk("t4_second", 32'(bcd_o), 32'h00300);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bcd_valid_o) pulses++;
        end
        chk("t4_no_more", 32'(pulses), 32'd0);
        chk("t4_idle",    32'(busy_o), 32'h0);

        // back-to-back load on the last shift cycle
        send(16'd5);
        bc = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy_o) bc++;
            step();
        end
        chk("t5_busy_a", 32'(bc), 32'd15);
        send(16'd777);
        chk("t5_vld",  32'(bcd_valid_o), 32'h1);
        chk("t5_bcd",  32'(bcd_o), 32'h00005);
        chk("t5_busy", 32'(busy_o), 32'h1);
        wait_next(cyc, bc);
        chk("t5_lat",    32'(cyc), 32'd16);
        chk("t5_busy_b", 32'(bc), 32'd16);
        chk("t5_bcd2",   32'(bcd_o), 32'h00777);

        // reset mid-conversion with pending full
        send(16'd4321);
        step(); step();
        send(16'd9);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6r_bcd",  32'(bcd_o), 32'h0);
        chk("t6r_busy", 32'(busy_o), 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bcd_valid_o) pulses++;
        end
        chk("t6r_pulses", 32'(pulses), 32'd0);

        // clear mid-conversion with pending full (after a nonzero, overflowed result)
        send(16'd54321);
        wait_next(cyc, bc);
        chk("t6_pre",     32'(bcd_o), 32'h54321);
        chk("t6_pre_o4",  32'(overflow4_o), 32'h1);
        send(16'd1234);
        step(); step();
        send(16'd42);
        step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("t6c_bcd",  32'(bcd_o), 32'h0);
        chk("t6c_ovf4", 32'(overflow4_o), 32'h0);
        chk("t6c_vld",  32'(bcd_valid_o), 32'h0);
        chk("t6c_busy", 32'(busy_o), 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bcd_valid_o) pulses++;
        end
        chk("t6c_pulses", 32'(pulses), 32'd0);

        // still functional after clear
        send(16'd808);
        wait_next(cyc, bc);
        chk("t7_lat", 32'(cyc), 32'd16);
        chk("t7_bcd", 32'(bcd_o), 32'h00808);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
